// File: rtl/kbd_scan.sv
// rtl/kbd_scan.sv - 4x4 keypad scanner with frame debounce and key history
// Optional history register: define KBD_WORD_EN.
module kbd_scan #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  row,
  output logic [3:0]  col,
  output logic        key_valid,
  output logic [7:0]  key_ascii,
  output logic        key_down,
  output logic [31:0] word
);

  localparam int TW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [TW-1:0] T_LAST  = TW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_SCANS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [4:0]    NONE    = 5'd16;

  logic [3:0]    sync1_q, sync2_q;
  logic [1:0]    c_q, c_d;
  logic [TW-1:0] t_q, t_d;
  logic [3:0]    col_q, col_d;
  logic [15:0]   frame_q, frame_d;
  logic [4:0]    cand_q, cand_d;
  logic [4:0]    stable_q, stable_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          key_valid_q, key_valid_d;
  logic [7:0]    key_ascii_q, key_ascii_d;
  logic          key_down_q, key_down_d;
  logic [4:0]    code;
  logic          sample;

  function automatic logic [7:0] key_to_ascii(input logic [3:0] idx);
    case (idx)
      4'd0:  key_to_ascii = "1";
      4'd1:  key_to_ascii = "4";
      4'd2:  key_to_ascii = "7";
      4'd3:  key_to_ascii = "0";
      4'd4:  key_to_ascii = "2";
      4'd5:  key_to_ascii = "5";
      4'd6:  key_to_ascii = "8";
      4'd7:  key_to_ascii = "f";
      4'd8:  key_to_ascii = "3";
      4'd9:  key_to_ascii = "6";
      4'd10: key_to_ascii = "9";
      4'd11: key_to_ascii = "e";
      4'd12: key_to_ascii = "a";
      4'd13: key_to_ascii = "b";
      4'd14: key_to_ascii = "c";
      default: key_to_ascii = "d";
    endcase
  endfunction

  always_comb begin
    c_d         = c_q;
    t_d         = t_q;
    frame_d     = frame_q;
    cand_d      = cand_q;
    stable_d    = stable_q;
    cnt_d       = cnt_q;
    key_valid_d = 1'b0;
    key_ascii_d = key_ascii_q;
    key_down_d  = key_down_q;
    code        = NONE;
    sample      = (t_q == T_LAST);

    if (sample) begin
      t_d = '0;
      c_d = c_q + 2'd1;
      frame_d[{c_q, 2'b00} +: 4] = ~sync2_q;
    end else begin
      t_d = t_q + 1'b1;
    end

    // Scan downward so the lowest pressed index wins.
    for (int i = 15; i >= 0; i--) begin
      if (frame_d[i]) code = 5'(i);
    end

    if (sample && c_q == 2'd3) begin
      if (code == cand_q) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
      end else begin
        cand_d = code;
        cnt_d  = CNT_ONE;
      end
      if (cnt_d == CNT_MAX && cand_d != stable_q) begin
        stable_d = cand_d;
        if (cand_d == NONE) begin
          key_down_d = 1'b0;
        end else begin
          key_valid_d = 1'b1;
          key_ascii_d = key_to_ascii(cand_d[3:0]);
          key_down_d  = 1'b1;
        end
      end
    end

    col_d = ~(4'b0001 << c_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q     <= 4'hF;
      sync2_q     <= 4'hF;
      c_q         <= 2'd0;
      t_q         <= '0;
      col_q       <= 4'b1110;
      frame_q     <= '0;
      cand_q      <= NONE;
      stable_q    <= NONE;
      cnt_q       <= '0;
      key_valid_q <= 1'b0;
      key_ascii_q <= 8'h20;
      key_down_q  <= 1'b0;
    end else begin
      sync1_q     <= row;
      sync2_q     <= sync1_q;
      c_q         <= c_d;
      t_q         <= t_d;
      col_q       <= col_d;
      frame_q     <= frame_d;
      cand_q      <= cand_d;
      stable_q    <= stable_d;
      cnt_q       <= cnt_d;
      key_valid_q <= key_valid_d;
      key_ascii_q <= key_ascii_d;
      key_down_q  <= key_down_d;
    end
  end

  assign col       = col_q;
  assign key_valid = key_valid_q;
  assign key_ascii = key_ascii_q;
  assign key_down  = key_down_q;

`ifdef KBD_WORD_EN
  logic [31:0] word_q, word_d;

  always_comb begin
    word_d = word_q;
    if (key_valid_d) word_d = {word_q[23:0], key_ascii_d};
  end

  always_ff @(posedge clk) begin
    if (reset) word_q <= 32'h20202020;
    else       word_q <= word_d;
  end

  assign word = word_q;
`else
  assign word = 32'h20202020;
`endif

endmodule

// File: tb/tb_kbd_scan.sv
// tb/tb_kbd_scan.sv - keypad model, key-event scoreboard and vector table for kbd_scan
module tb_kbd_scan;

  localparam int FRAME = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [7:0]  key_ascii;
  logic        key_down;
  logic [31:0] word;
  logic [15:0] keys = '0;

  int checks = 0;
  int failures = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    logic [15:0] mask;
    logic [7:0]  ascii;
  } vec_t;
  vec_t vecs[5];

  kbd_scan #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk(clk), .reset(reset), .row(row), .col(col),
    .key_valid(key_valid), .key_ascii(key_ascii), .key_down(key_down), .word(word)
  );

  always #5 clk = ~clk;

  // Closed switch at (c,r) pulls row r low while column c is driven low.
  always_comb begin
    row = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (keys[c*4+r] && !col[c]) row[r] = 1'b0;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (!reset && key_valid) begin
      if (exp_q.size() == 0) check("unexpected_pulse", {24'h0, key_ascii}, 32'h0);
      else check("pulse_ascii", {24'h0, key_ascii}, {24'h0, exp_q.pop_front()});
    end
  end

  task automatic wait_frames(input int n);
    repeat (n * FRAME) @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string name, input logic [31:0] enabled_val);
    @(negedge clk);
`ifdef KBD_WORD_EN
    check(name, word, enabled_val);
`else
    check(name, word, 32'h20202020);
`endif
  endtask

  task automatic check_reset_state();
    @(negedge clk);
    check("rst_col", {28'h0, col}, 32'he);
    check("rst_valid", {31'h0, key_valid}, 32'h0);
    check("rst_down", {31'h0, key_down}, 32'h0);
    check("rst_ascii", {24'h0, key_ascii}, 32'h20);
    check("rst_word", word, 32'h20202020);
  endtask

  initial begin
    vecs[0] = '{16'h1000, 8'h61};
    vecs[1] = '{16'h2000, 8'h62};
    vecs[2] = '{16'h4000, 8'h63};
    vecs[3] = '{16'h8000, 8'h64};
    vecs[4] = '{16'h0800, 8'h65};

    repeat (3) @(posedge clk);
    check_reset_state();
    @(posedge clk);
    #1 reset = 1'b0;

    // Idle: column walk and no pulses.
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      check("idle_col", {28'h0, col}, {28'h0, ~(4'b0001 << ((k / 4) % 4))});
    end
    check("idle_word", word, 32'h20202020);

    // Single press of '8' held for 10 frames.
    exp_q.push_back(8'h38);
    keys = 16'h0040;
    wait_frames(10);
    @(negedge clk);
    check("k8_down", {31'h0, key_down}, 32'h1);
    check("k8_ascii", {24'h0, key_ascii}, 32'h38);
    check_word("k8_word", 32'h20202038);
    keys = '0;
    wait_frames(4);
    @(negedge clk);
    check("k8_release", {31'h0, key_down}, 32'h0);

    // Bouncy '3': alternates each frame, then held.
    for (int i = 0; i < 4; i++) begin
      keys = (i % 2 == 0) ? 16'h0100 : 16'h0000;
      wait_frames(1);
    end
    exp_q.push_back(8'h33);
    keys = 16'h0100;
    wait_frames(4);
    @(negedge clk);
    check("k3_ascii", {24'h0, key_ascii}, 32'h33);
    keys = '0;
    wait_frames(4);

    // Hold '1', add 'd' (no event), release '1' -> 'd'.
    exp_q.push_back(8'h31);
    keys = 16'h0001;
    wait_frames(4);
    keys = 16'h8001;
    wait_frames(4);
    @(negedge clk);
    check("k1d_ascii", {24'h0, key_ascii}, 32'h31);
    check("k1d_queue", exp_q.size(), 0);
    exp_q.push_back(8'h64);
    keys = 16'h8000;
    wait_frames(4);
    @(negedge clk);
    check("kd_ascii", {24'h0, key_ascii}, 32'h64);
    check("kd_down", {31'h0, key_down}, 32'h1);
    keys = '0;
    wait_frames(4);

    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(vecs[i].ascii);
      keys = vecs[i].mask;
      wait_frames(4);
      @(negedge clk);
      check("vec_down", {31'h0, key_down}, 32'h1);
      check("vec_ascii", {24'h0, key_ascii}, {24'h0, vecs[i].ascii});
      keys = '0;
      wait_frames(4);
      @(negedge clk);
      check("vec_up", {31'h0, key_down}, 32'h0);
      check("vec_hold_ascii", {24'h0, key_ascii}, {24'h0, vecs[i].ascii});
    end
    check_word("vec_word", 32'h62636465);

    // Reset partway through a '5' debounce, key held throughout.
    keys = 16'h0020;
    wait_frames(1);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    check_reset_state();
    @(posedge clk);
    #1;
    exp_q.push_back(8'h35);
    reset = 1'b0;
    wait_frames(4);
    @(negedge clk);
    check("k5_ascii", {24'h0, key_ascii}, 32'h35);
    check("k5_down", {31'h0, key_down}, 32'h1);
    check_word("k5_word", 32'h20202035);
    keys = '0;
    wait_frames(4);

    check("sb_pending", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
